// File: rtl/timing_stim_gen_if.sv
// Data-stream handshake for timing_stim_gen: the producer offers one bit per
// slot and the generator signals the tick on which that bit is consumed.
interface timing_stim_gen_if;
    logic in_valid;
    logic in_data;
    logic in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/timing_stim_gen.sv
// timing_stim_gen: drives a generated clock, data and reset with programmable
// recovery, period, duty, and data-change point relative to the clock edge.
// Used to exercise setup/hold/recovery behaviour of a downstream block.
module timing_stim_gen #(
    parameter int CNT_W  = 8,
    parameter int NCYC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  high_time,
    input  logic [CNT_W-1:0]  setup_ticks,
    input  logic [CNT_W-1:0]  hold_ticks,
    input  logic [CNT_W-1:0]  recov_ticks,
    input  logic [NCYC_W-1:0] num_cycles,
    timing_stim_gen_if.slave  in_if,
    output logic              clk_out,
    output logic              d_out,
    output logic              rst_out,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              underrun
);

    typedef enum logic [1:0] {S_IDLE, S_RECOV, S_RUN, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   phase_reg, phase_next;
    logic [NCYC_W-1:0]  cycle_reg, cycle_next;

    // Configuration captured at start; live inputs are ignored afterwards.
    logic [CNT_W-1:0]   period_reg, high_reg, hold_reg, recov_reg;
    logic [NCYC_W-1:0]  ncyc_reg;
    logic               cfg_latch;

    logic               clk_out_reg, clk_out_next;
    logic               d_out_reg, d_out_next;
    logic               rst_out_reg, rst_out_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               cfg_err_reg, cfg_err_next;

    logic               cfg_illegal;
    logic [CNT_W:0]     su_ho_sum;
    logic               data_slot;
    logic [CNT_W-1:0]   high_eff;

    // Setup plus hold must fit in one period; widened so the sum cannot wrap.
    assign su_ho_sum   = {1'b0, setup_ticks} + {1'b0, hold_ticks};
    assign cfg_illegal = (period < CNT_W'(2)) || (high_time == '0) ||
                         (high_time >= period) || (su_ho_sum > {1'b0, period}) ||
                         (num_cycles == '0);

    // The data slot is the phase where d_out is allowed to change.
    assign data_slot      = (state_reg == S_RUN) && (phase_reg == hold_reg);
    assign in_if.in_ready = data_slot && in_if.in_valid;
    assign underrun       = data_slot && !in_if.in_valid;

    // When the sequence is being launched this tick the registered config is
    // not yet valid, so the duty comparison uses the live input.
    assign high_eff = cfg_latch ? high_time : high_reg;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        cycle_next   = cycle_reg;
        cfg_latch    = 1'b0;
        cfg_err_next = 1'b0;
        d_out_next   = in_if.in_ready ? in_if.in_data : d_out_reg;

        case (state_reg)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_illegal) begin
                        cfg_err_next = 1'b1;
                    end else begin
                        cfg_latch  = 1'b1;
                        phase_next = '0;
                        cycle_next = '0;
                        state_next = (recov_ticks == '0) ? S_RUN : S_RECOV;
                    end
                end
            end
            S_RECOV: begin
                // phase_reg doubles as the recovery tick counter.
                if (phase_reg == recov_reg - CNT_W'(1)) begin
                    state_next = S_RUN;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (phase_reg == period_reg - CNT_W'(1)) begin
                    phase_next = '0;
                    if (cycle_reg == ncyc_reg - NCYC_W'(1)) begin
                        state_next = S_DONE;
                    end else begin
                        cycle_next = cycle_reg + NCYC_W'(1);
                    end
                end else begin
                    phase_next = phase_reg + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort) begin
            state_next = S_IDLE;
            phase_next = '0;
            cycle_next = '0;
        end

        clk_out_next = (state_next == S_RUN) && (phase_next < high_eff);
        rst_out_next = (state_next == S_IDLE);
        busy_next    = (state_next == S_RECOV) || (state_next == S_RUN);
        done_next    = (state_next == S_DONE);
    end

    // State, counters and glitch-free registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            phase_reg   <= '0;
            cycle_reg   <= '0;
            clk_out_reg <= 1'b0;
            d_out_reg   <= 1'b0;
            rst_out_reg <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            cycle_reg   <= cycle_next;
            clk_out_reg <= clk_out_next;
            d_out_reg   <= d_out_next;
            rst_out_reg <= rst_out_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    // Configuration capture on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_reg <= '0;
            high_reg   <= '0;
            hold_reg   <= '0;
            recov_reg  <= '0;
            ncyc_reg   <= '0;
        end else if (cfg_latch) begin
            period_reg <= period;
            high_reg   <= high_time;
            hold_reg   <= hold_ticks;
            recov_reg  <= recov_ticks;
            ncyc_reg   <= num_cycles;
        end
    end

    assign clk_out = clk_out_reg;
    assign d_out   = d_out_reg;
    assign rst_out = rst_out_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_timing_stim_gen.sv
// Scoreboard bench for timing_stim_gen: each directed tick pushes its
// hand-computed output vector; a negedge monitor pops and compares.
module tb_timing_stim_gen;

    localparam int CNT_W  = 8;
    localparam int NCYC_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  period = '0;
    logic [CNT_W-1:0]  high_time = '0;
    logic [CNT_W-1:0]  setup_ticks = '0;
    logic [CNT_W-1:0]  hold_ticks = '0;
    logic [CNT_W-1:0]  recov_ticks = '0;
    logic [NCYC_W-1:0] num_cycles = '0;
    logic clk_out, d_out, rst_out, busy, done, cfg_err, underrun;

    timing_stim_gen_if sif ();

    timing_stim_gen #(.CNT_W(CNT_W), .NCYC_W(NCYC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .period(period), .high_time(high_time), .setup_ticks(setup_ticks),
        .hold_ticks(hold_ticks), .recov_ticks(recov_ticks), .num_cycles(num_cycles),
        .in_if(sif),
        .clk_out(clk_out), .d_out(d_out), .rst_out(rst_out), .busy(busy),
        .done(done), .cfg_err(cfg_err), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         tick;
        logic [7:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int errors = 0;
    int checks = 0;

    // Stimulus vectors (index = tick) and expected output vectors.
    logic [0:15] st_v, ab_v, iv_v, id_v, rs_v;
    logic [0:15] e_rst, e_busy, e_clk, e_rdy, e_d, e_done, e_cfg, e_und;

    // Monitor: vector order {rst_out, busy, clk_out, in_ready, d_out, done, cfg_err, underrun}
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {rst_out, busy, clk_out, sif.in_ready, d_out, done, cfg_err, underrun};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s tick %0d: got %b expected %b (rst_out,busy,clk_out,in_ready,d_out,done,cfg_err,underrun)",
                         e.name, e.tick, act, e.exp);
            end else begin
                $display("ok   %s tick %0d: %b", e.name, e.tick, act);
            end
        end
    end

    task automatic clr();
        st_v = '0; ab_v = '0; iv_v = '1; id_v = '0; rs_v = '0;
        e_rst = '0; e_busy = '0; e_clk = '0; e_rdy = '0;
        e_d = '0; e_done = '0; e_cfg = '0; e_und = '0;
    endtask

    task automatic set_cfg(input int p, input int h, input int s, input int hd,
                           input int r, input int n);
        period      = CNT_W'(p);
        high_time   = CNT_W'(h);
        setup_ticks = CNT_W'(s);
        hold_ticks  = CNT_W'(hd);
        recov_ticks = CNT_W'(r);
        num_cycles  = NCYC_W'(n);
    endtask

    task automatic run(input string name, input int n);
        sb_entry_t ent;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            rst          = rs_v[t];
            start        = st_v[t];
            abort        = ab_v[t];
            sif.in_valid = iv_v[t];
            sif.in_data  = id_v[t];
            ent.name = name;
            ent.tick = t;
            ent.exp  = {e_rst[t], e_busy[t], e_clk[t], e_rdy[t],
                        e_d[t], e_done[t], e_cfg[t], e_und[t]};
            sb_q.push_back(ent);
        end
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = 1'b0;

        // Reset held: idle outputs, rst_out high.
        clr();
        rs_v = '1; iv_v = '0; e_rst = '1;
        run("reset", 3);

        // Basic sequence.
        clr();
        set_cfg(4, 2, 1, 1, 3, 2);
        st_v   = 16'b1000000000000000;
        id_v   = 16'b1111110000000000;
        e_rst  = 16'b1000000000000110;
        e_busy = 16'b0111111111110000;
        e_clk  = 16'b0000110011000000;
        e_rdy  = 16'b0000010001000000;
        e_d    = 16'b0000001111000000;
        e_done = 16'b0000000000001000;
        run("basic", 15);

        // Rejected configurations.
        clr();
        st_v  = 16'b1000000000000000;
        e_rst = '1;
        e_cfg = 16'b0100000000000000;
        set_cfg(4, 4, 1, 1, 3, 2);
        run("rej_high", 3);
        set_cfg(4, 2, 3, 2, 3, 2);
        run("rej_su_ho", 3);
        set_cfg(4, 2, 1, 1, 3, 0);
        run("rej_ncyc", 3);

        // Underrun at the second data slot.
        clr();
        set_cfg(4, 2, 1, 1, 3, 2);
        st_v   = 16'b1000000000000000;
        iv_v   = 16'b1111111110111111;
        id_v   = 16'b1111110000000000;
        e_rst  = 16'b1000000000000110;
        e_busy = 16'b0111111111110000;
        e_clk  = 16'b0000110011000000;
        e_rdy  = 16'b0000010000000000;
        e_und  = 16'b0000000001000000;
        e_d    = 16'b0000001111111110;
        e_done = 16'b0000000000001000;
        run("underrun", 15);

        // Abort at tick 6 with start held; d_out starts at 1.
        clr();
        set_cfg(4, 2, 1, 1, 3, 2);
        st_v   = 16'b1000001000000000;
        ab_v   = 16'b0000001000000000;
        e_rst  = 16'b1000000111111111;
        e_busy = 16'b0111111000000000;
        e_clk  = 16'b0000110000000000;
        e_rdy  = 16'b0000010000000000;
        e_d    = 16'b1111110000000000;
        run("abort", 13);

        // Zero hold and zero recovery: data changes on the rising edge.
        clr();
        set_cfg(4, 2, 1, 0, 0, 2);
        st_v   = 16'b1000000000000000;
        id_v   = '1;
        e_rst  = 16'b1000000000111111;
        e_busy = 16'b0111111110000000;
        e_clk  = 16'b0110011000000000;
        e_rdy  = 16'b0100010000000000;
        e_d    = 16'b0011111111111111;
        e_done = 16'b0000000001000000;
        run("hold0", 12);

        // Asynchronous reset mid-sequence; d_out starts at 1.
        clr();
        set_cfg(4, 2, 1, 1, 3, 2);
        st_v   = 16'b1000000000000000;
        id_v   = '1;
        rs_v   = 16'b0000010000000000;
        e_rst  = 16'b1000011111111111;
        e_busy = 16'b0111100000000000;
        e_clk  = 16'b0000100000000000;
        e_d    = 16'b1111100000000000;
        run("async_rst", 14);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timing_stim_gen.md
TIMING_STIM_GEN -- requirements
Module: timing_stim_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of all tick-count fields and the phase counter.
REQ-002 SHALL have parameter NCYC_W, default 16, width of the cycle-count field.
REQ-003 SHALL have port clk  input  1  base clock; every tick below is one clk cycle.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  latch configuration and begin a sequence; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate any sequence.
REQ-007 SHALL have port period  input  CNT_W  generated clock period in ticks.
REQ-008 SHALL have port high_time  input  CNT_W  ticks clk_out is high per period.
REQ-009 SHALL have port setup_ticks  input  CNT_W  minimum ticks d_out is stable before each rising edge of clk_out.
REQ-010 SHALL have port hold_ticks  input  CNT_W  ticks after a rising edge of clk_out at which d_out changes.
REQ-011 SHALL have port recov_ticks  input  CNT_W  ticks from rst_out release to the first rising edge of clk_out.
REQ-012 SHALL have port num_cycles  input  NCYC_W  number of generated clock periods.
REQ-013 SHALL have port in_valid  input  1  in_data is offered.
REQ-014 SHALL have port in_data  input  1  next data bit.
REQ-015 SHALL have port in_ready  output  1  in_data is consumed this tick.
REQ-016 SHALL have port clk_out  output  1  generated clock.
REQ-017 SHALL have port d_out  output  1  generated data.
REQ-018 SHALL have port rst_out  output  1  generated reset, active-high.
REQ-019 SHALL have port busy  output  1  sequence in progress (RECOV or RUN).
REQ-020 SHALL have port done  output  1  one-tick pulse at normal completion.
REQ-021 SHALL have port cfg_err  output  1  one-tick pulse when start is rejected.
REQ-022 SHALL have port underrun  output  1  one-tick pulse when a data slot finds in_valid low.

Function
REQ-023 SHALL implement states IDLE, RECOV, RUN and DONE.
REQ-024 In IDLE, start=1 with a legal configuration SHALL latch all configuration inputs and enter RECOV on the next tick; configuration inputs SHALL be ignored thereafter until IDLE.
REQ-025 Configuration SHALL be illegal when period<2, high_time==0, high_time>=period, setup_ticks+hold_ticks>period (sum computed at CNT_W+1 bits), or num_cycles==0.
REQ-026 An illegal configuration SHALL pulse cfg_err for one tick and leave the state in IDLE.
REQ-027 rst_out SHALL be 1 in IDLE and 0 in RECOV, RUN and DONE.
REQ-028 RECOV SHALL last exactly recov_ticks ticks, then enter RUN at phase 0; recov_ticks==0 SHALL enter RUN directly from IDLE, one tick after start.
REQ-029 In RUN, a phase counter SHALL count 0..period-1 and wrap to 0, and a cycle counter SHALL increment at each wrap.
REQ-030 clk_out SHALL be 1 exactly when the state is RUN and phase<high_time; otherwise it SHALL be 0.
REQ-031 in_ready SHALL be 1 exactly when the state is RUN, phase==hold_ticks and in_valid=1.
REQ-032 On an in_ready tick, d_out SHALL take in_data from the next tick onward.
REQ-033 When the state is RUN, phase==hold_ticks and in_valid=0, d_out SHALL hold its value and underrun SHALL pulse.
REQ-034 hold_ticks==0 SHALL be legal, so d_out may change coincident with the rising edge (deliberate hold-violation stimulus).
REQ-035 After the last phase of cycle num_cycles, RUN SHALL enter DONE; DONE SHALL pulse done for one tick and then enter IDLE.
REQ-036 start seen outside IDLE SHALL be ignored.
REQ-037 abort in any state SHALL force IDLE on the next tick with clk_out=0 and rst_out=1, without a done pulse; abort SHALL take priority over start.
REQ-038 d_out SHALL retain its last value across DONE, abort and IDLE.
REQ-039 busy SHALL be 1 exactly when the state is RECOV or RUN.

Reset
REQ-040 rst=1 SHALL immediately force IDLE with clk_out=0, d_out=0, rst_out=1, and busy, done, cfg_err, underrun and in_ready all 0, and SHALL clear the phase and cycle counters.
REQ-041 Reset asserted mid-sequence SHALL discard the sequence; no done pulse SHALL follow.

Verification
REQ-042 period=4, high_time=2, hold_ticks=1, setup_ticks=1, recov_ticks=3, num_cycles=2, in_valid held 1, in_data=1,0; start at tick 0 -> rst_out falls at tick 1; clk_out high at ticks 4-5 and 8-9; in_ready at ticks 5 and 9; d_out=1 from tick 6 and 0 from tick 10; done at tick 12; IDLE at tick 13.
REQ-043 Rejected configurations: period=4, high_time=4; then setup_ticks=3, hold_ticks=2; then num_cycles=0 -> each gives one cfg_err pulse, busy stays 0, rst_out stays 1.
REQ-044 Sequence as REQ-042 with in_valid=0 at tick 9 -> underrun pulses at tick 9 and d_out holds 1.
REQ-045 abort at tick 6 of REQ-042, with start also held 1 -> tick 7 in IDLE, clk_out=0, rst_out=1, no done pulse, no restart.
REQ-046 hold_ticks=0, recov_ticks=0 -> RUN begins at tick 1; in_ready coincides with each tick where phase=0 and clk_out rises.
REQ-047 rst pulse at tick 5 of REQ-042 -> all outputs take their reset values without waiting for a clk edge, and no done pulse follows.
